// File: rtl/dtt_crossbar_egress_if.sv
// Egress FIFO bus: crossbar-side push (no backpressure) and consumer-side valid/ready pop.
// The master modport is the surrounding logic; the slave modport is the FIFO itself.
interface dtt_crossbar_egress_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] xb_data;
    logic                  xb_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output xb_data, xb_valid, m_ready,
        input  m_data, m_valid
    );

    modport slave (
        input  xb_data, xb_valid, m_ready,
        output m_data, m_valid
    );
endinterface

// File: rtl/dtt_crossbar_egress.sv
// First-word-fall-through egress FIFO behind one crossbar output; words arriving when full are dropped.
// Define DTT_EGRESS_STATS_EN to add stat_clr, drop_count (saturating) and the sticky overflow flag.
module dtt_crossbar_egress #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dtt_crossbar_egress_if.slave    bus,
    output logic [$clog2(DEPTH):0]  level
`ifdef DTT_EGRESS_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [CNT_WIDTH-1:0]    drop_count,
    output logic                    overflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dtt_crossbar_egress: DEPTH must be a power of two, at least 2");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("dtt_crossbar_egress: CNT_WIDTH must be at least 1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Extra pointer MSB tells full from empty when the index bits match.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop   = !empty && bus.m_ready;
        push  = bus.xb_valid && (!full || pop);
    end

    // Outputs come straight from state, so they never see m_ready or xb_valid.
    assign bus.m_valid = !empty;
    assign bus.m_data  = mem[rd_ptr[AW-1:0]];
    assign level       = wr_ptr - rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.xb_data;
    end

`ifdef DTT_EGRESS_STATS_EN
    logic drop;

    assign drop = bus.xb_valid && full && !pop;

    // A clear coincident with a discard leaves that discard counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (stat_clr) begin
            drop_count <= CNT_WIDTH'(drop);
            overflow   <= drop;
        end else if (drop) begin
            if (drop_count != '1) drop_count <= drop_count + CNT_WIDTH'(1);
            overflow <= 1'b1;
        end
    end
`endif

endmodule
